// File: rtl/vl_beat_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : vl_beat_sequencer_if
// Description : Command/beat bundle between the issue stage, the beat
//               sequencer and the lane/VRF access logic.
//               master : issue stage + beat consumer (drives cmd_*, config,
//                        beat_ready)
//               slave  : vl_beat_sequencer
//               Signals: cmd_valid/cmd_ready, avl, sew, vill,
//                        beat_valid/beat_ready, beat_idx, beat_be,
//                        beat_first, beat_last, done, err
// Revision    : 1.0 - initial release
// ============================================================================
interface vl_beat_sequencer_if #(
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64
);
  localparam int VLEN_B_BITS = $clog2(VLEN >> 3);
  localparam int BPB         = DATA_WIDTH / 8;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [VLEN_B_BITS-1:0] avl;
  logic [1:0]             sew;
  logic                   vill;
  logic                   beat_valid;
  logic                   beat_ready;
  logic [VLEN_B_BITS-1:0] beat_idx;
  logic [BPB-1:0]         beat_be;
  logic                   beat_first;
  logic                   beat_last;
  logic                   done;
  logic                   err;

  modport master (
    output cmd_valid, avl, sew, vill, beat_ready,
    input  cmd_ready, beat_valid, beat_idx, beat_be, beat_first, beat_last,
           done, err
  );

  modport slave (
    input  cmd_valid, avl, sew, vill, beat_ready,
    output cmd_ready, beat_valid, beat_idx, beat_be, beat_first, beat_last,
           done, err
  );
endinterface
`default_nettype wire

// File: rtl/vl_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vl_beat_sequencer
// Description : Splits one vector instruction (avl elements of width sew)
//               into DATA_WIDTH-wide beats carrying byte enables, first/last
//               markers and a beat index. Reports completion with a one-cycle
//               done pulse (err alongside it for rejected commands).
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - vl_beat_sequencer_if.slave (command + beat stream)
// Options     : RVV_SEW64_EN - when defined, sew=3 (64-bit elements) is
//               legal; otherwise such commands are rejected with err.
// Revision    : 1.0 - initial release
// ============================================================================
module vl_beat_sequencer #(
  parameter int VLEN        = 16384,
  parameter int DATA_WIDTH  = 64,
  parameter int VLMAX       = VLEN >> 3,
  parameter int VLEN_B_BITS = $clog2(VLMAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  vl_beat_sequencer_if.slave bus
);

  localparam int BPB  = DATA_WIDTH / 8;
  // avl << 3 must fit without overflow.
  localparam int TB_W = VLEN_B_BITS + 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_q,      state_d;
  logic [TB_W-1:0]        rem_q,        rem_d;
  logic [VLEN_B_BITS-1:0] beat_idx_q,   beat_idx_d;
  logic [BPB-1:0]         beat_be_q,    beat_be_d;
  logic                   beat_valid_q, beat_valid_d;
  logic                   beat_first_q, beat_first_d;
  logic                   beat_last_q,  beat_last_d;
  logic                   done_q,       done_d;
  logic                   err_q,        err_d;

  logic [TB_W-1:0]        cmd_bytes;
  logic                   sew_ok;
  logic                   cmd_fire;
  logic                   beat_fire;
  logic [TB_W-1:0]        rem_next;

  // Byte enables for a beat with 'rem' bytes still outstanding: bit i is set
  // when byte i is still part of the vector, which saturates to all ones once
  // rem >= BPB.
  function automatic logic [BPB-1:0] be_for(input logic [TB_W-1:0] rem);
    logic [BPB-1:0] be;
    be = '0;
    for (int i = 0; i < BPB; i++) begin
      be[i] = (rem > TB_W'(i));
    end
    return be;
  endfunction

  assign cmd_fire  = bus.cmd_valid && (state_q == ST_IDLE);
  assign beat_fire = beat_valid_q && bus.beat_ready;
  assign rem_next  = rem_q - TB_W'(BPB);

  // Byte count of the incoming command; the sew=3 path only exists when
  // 64-bit elements are enabled.
  always_comb begin
    cmd_bytes = '0;
    sew_ok    = 1'b1;
    case (bus.sew)
      2'd0: cmd_bytes = TB_W'(bus.avl);
      2'd1: cmd_bytes = {2'b00, bus.avl, 1'b0};
      2'd2: cmd_bytes = {1'b0, bus.avl, 2'b00};
      2'd3: begin
`ifdef RVV_SEW64_EN
        cmd_bytes = {bus.avl, 3'b000};
`else
        sew_ok    = 1'b0;
`endif
      end
      default: sew_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    beat_idx_d   = beat_idx_q;
    beat_be_d    = beat_be_q;
    beat_valid_d = beat_valid_q;
    beat_first_d = beat_first_q;
    beat_last_d  = beat_last_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (bus.vill || !sew_ok || (bus.avl == '0)) begin
            // Rejected or empty: complete immediately, no beats.
            done_d = 1'b1;
            err_d  = bus.vill || !sew_ok;
          end else begin
            state_d      = ST_RUN;
            rem_d        = cmd_bytes;
            beat_idx_d   = '0;
            beat_valid_d = 1'b1;
            beat_first_d = 1'b1;
            beat_be_d    = be_for(cmd_bytes);
            beat_last_d  = (cmd_bytes <= TB_W'(BPB));
          end
        end
      end
      ST_RUN: begin
        if (beat_fire) begin
          if (beat_last_q) begin
            state_d      = ST_IDLE;
            rem_d        = '0;
            beat_idx_d   = '0;
            beat_valid_d = 1'b0;
            beat_first_d = 1'b0;
            beat_be_d    = '0;
            beat_last_d  = 1'b0;
            done_d       = 1'b1;
          end else begin
            // Next beat's enables/last are precomputed so the outputs stay
            // registered with no path from beat_ready.
            rem_d        = rem_next;
            beat_idx_d   = beat_idx_q + VLEN_B_BITS'(1);
            beat_first_d = 1'b0;
            beat_be_d    = be_for(rem_next);
            beat_last_d  = (rem_next <= TB_W'(BPB));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      beat_idx_q   <= '0;
      beat_be_q    <= '0;
      beat_valid_q <= 1'b0;
      beat_first_q <= 1'b0;
      beat_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      beat_idx_q   <= beat_idx_d;
      beat_be_q    <= beat_be_d;
      beat_valid_q <= beat_valid_d;
      beat_first_q <= beat_first_d;
      beat_last_q  <= beat_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_be    = beat_be_q;
  assign bus.beat_first = beat_first_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vl_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vl_beat_sequencer
// Description : Self-checking bench for vl_beat_sequencer. Expected beats are
//               computed from the element count and width with plain
//               arithmetic; beat_ready is driven always-on, in a 1,0,0
//               pattern, or randomly.
// Options     : RVV_SEW64_EN - must match the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vl_beat_sequencer;

  localparam int VLEN = 16384;
  localparam int DW   = 64;
  localparam int BPB  = DW / 8;
  localparam int AW   = $clog2(VLEN >> 3);
`ifdef RVV_SEW64_EN
  localparam bit SEW64 = 1'b1;
`else
  localparam bit SEW64 = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vl_beat_sequencer_if #(.VLEN(VLEN), .DATA_WIDTH(DW)) bus ();

  vl_beat_sequencer #(.VLEN(VLEN), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Issue one command at a negedge and follow it to completion. Returns at
  // the negedge where done is observed, so a following call issues in the
  // done cycle. mode: 0 ready always, 1 ready pattern 1,0,0, 2 random.
  task automatic do_cmd(input int avl, input int sew, input bit vill,
                        input int mode, input string tag);
    int        bytes, n, k, cyc, rem;
    bit        exp_err, reject, r;
    logic [7:0] exp_be;
    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready: got %b want 1", tag, bus.cmd_ready);
      return;
    end
    exp_err = vill || (sew == 3 && !SEW64);
    reject  = exp_err || (avl == 0);
    bytes   = avl * (1 << sew);
    n       = (bytes + BPB - 1) / BPB;

    bus.cmd_valid = 1'b1;
    bus.avl       = AW'(avl);
    bus.sew       = 2'(sew);
    bus.vill      = vill;
    @(negedge clk);
    // Config inputs change to junk after the handshake; they must be ignored.
    bus.cmd_valid = 1'b0;
    bus.avl       = AW'($urandom);
    bus.sew       = 2'($urandom);
    bus.vill      = 1'($urandom);

    if (reject) begin
      checks++;
      if ({bus.beat_valid, bus.done, bus.err} !== {1'b0, 1'b1, exp_err}) begin
        errors++;
        $display("FAIL %s reject: got valid=%b done=%b err=%b want valid=0 done=1 err=%b",
                 tag, bus.beat_valid, bus.done, bus.err, exp_err);
      end
      return;
    end

    k   = 0;
    cyc = 0;
    while (k < n && cyc < 40 * n + 40) begin
      rem    = bytes - k * BPB;
      exp_be = (rem >= BPB) ? 8'hFF : 8'((1 << rem) - 1);
      checks++;
      if ({bus.beat_valid, bus.beat_idx, bus.beat_be, bus.beat_first,
           bus.beat_last, bus.done} !==
          {1'b1, AW'(k), exp_be, (k == 0), (rem <= BPB), 1'b0}) begin
        errors++;
        $display("FAIL %s beat%0d: got v=%b idx=%0d be=%h f=%b l=%b done=%b want v=1 idx=%0d be=%h f=%b l=%b done=0",
                 tag, k, bus.beat_valid, bus.beat_idx, bus.beat_be,
                 bus.beat_first, bus.beat_last, bus.done,
                 k, exp_be, (k == 0), (rem <= BPB));
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.beat_ready = r;
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    bus.beat_ready = 1'b0;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, n);
      return;
    end
    checks++;
    if ({bus.done, bus.err, bus.beat_valid, bus.cmd_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL %s done: got done=%b err=%b valid=%b ready=%b want 1 0 0 1",
               tag, bus.done, bus.err, bus.beat_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.cmd_ready, bus.beat_valid, bus.beat_idx, bus.beat_be,
         bus.beat_first, bus.beat_last, bus.done, bus.err} !==
        {1'b1, 1'b0, AW'(0), 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset: got ready=%b valid=%b idx=%0d be=%h f=%b l=%b done=%b err=%b want 1 0 0 00 0 0 0 0",
               bus.cmd_ready, bus.beat_valid, bus.beat_idx, bus.beat_be,
               bus.beat_first, bus.beat_last, bus.done, bus.err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_cmd(10, 0, 1'b0, 0, "avl10_sew0");
    do_cmd(4, 2, 1'b0, 0, "avl4_sew2");
  endtask

  task automatic test_back_to_back();
    // Called right after test_basic returns in its done cycle.
    do_cmd(1, 1, 1'b0, 0, "b2b_avl1_sew1");
  endtask

  task automatic test_reject();
    do_cmd(0, 0, 1'b0, 0, "avl0");
    do_cmd(5, 0, 1'b1, 0, "vill");
  endtask

  task automatic test_backpressure();
    do_cmd(20, 0, 1'b0, 1, "stall_avl20");
  endtask

  task automatic test_sew64();
    do_cmd(3, 3, 1'b0, 0, "sew64");
  endtask

  task automatic test_reset_midrun();
    int cyc;
    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.cmd_valid = 1'b1;
    bus.avl       = AW'(64);
    bus.sew       = 2'd0;
    bus.vill      = 1'b0;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.beat_valid, bus.beat_idx} !== {1'b1, AW'(1)}) begin
      errors++;
      $display("FAIL midrun idx1: got valid=%b idx=%0d want 1 1",
               bus.beat_valid, bus.beat_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.beat_valid, bus.beat_idx, bus.beat_be,
         bus.beat_first, bus.beat_last, bus.done, bus.err} !==
        {1'b1, 1'b0, AW'(0), 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b idx=%0d be=%h f=%b l=%b done=%b err=%b want 1 0 0 00 0 0 0 0",
               bus.cmd_ready, bus.beat_valid, bus.beat_idx, bus.beat_be,
               bus.beat_first, bus.beat_last, bus.done, bus.err);
    end
    bus.beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.done, bus.beat_valid} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_quiet: got done=%b valid=%b want 0 0",
                 bus.done, bus.beat_valid);
      end
    end
    do_cmd(12, 0, 1'b0, 2, "after_reset");
  endtask

  task automatic test_random();
    int avl, sew, mode;
    bit vill;
    for (int i = 0; i < 40; i++) begin
      avl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                         : int'($urandom_range(0, 40));
      sew  = int'($urandom_range(0, 3));
      vill = ($urandom_range(0, 9) == 0);
      mode = int'($urandom_range(0, 2));
      do_cmd(avl, sew, vill, mode, $sformatf("rand%0d", i));
      // Sometimes idle between commands.
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.avl        = '0;
    bus.sew        = '0;
    bus.vill       = 1'b0;
    bus.beat_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reject();
    test_backpressure();
    test_sew64();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
